// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the coordinate type used by every drawer.
// Default mode is 640x480@60 on a 25 MHz pixel clock.
package vga_timing_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;

   localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam int COORD_W   = 10;
   typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_delay_line.sv
// Width x depth shift register with asynchronous reset to RST_VAL.
// DEPTH=0 degenerates to a combinational pass-through.
module vga_delay_line #(
   parameter int               WIDTH   = 2,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign q = d;
      end else begin : g_shift
         logic [WIDTH-1:0] stage [DEPTH];

         // NOTE: every stage is reset so the syncs read inactive, not X, until the pipe refills.
         always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else begin
               stage[0] <= d;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign q = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel timing source: DrawX/DrawY/blank/frame_start plus pipeline-delayed hs_n/vs_n.
// Define VGA_TIMING_FRAME_CNT_EN to build the frame_count register; otherwise it reads 0.
module vga_timing_gen import vga_timing_pkg::*; #(
   parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
   parameter int H_FP      = vga_timing_pkg::H_FP,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BP      = vga_timing_pkg::H_BP,
   parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
   parameter int V_FP      = vga_timing_pkg::V_FP,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BP      = vga_timing_pkg::V_BP,
   parameter int SYNC_DLY  = 2
) (
   input  logic         vga_clk,
   input  logic         reset_n,
   output coord_t       DrawX,
   output coord_t       DrawY,
   output logic         blank,
   output logic         hs_n,
   output logic         vs_n,
   output logic         frame_start,
   output logic [15:0]  frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
   end
   if (SYNC_DLY < 0 || SYNC_DLY > 7) begin : g_bad_dly
      $fatal(1, "vga_timing_gen: SYNC_DLY must be 0..7");
   end

   localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
   localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

   // run stays low for the first edge after reset so that edge presents (0,0) with frame_start.
   logic   run;
   coord_t hc, vc;
   coord_t hc_nxt, vc_nxt;
   logic   blank_nxt, fs_nxt;
   logic   hs_raw, vs_raw;

   // NOTE: defaults first in always_comb so no path leaves a next-state value unassigned (no latch).
   always_comb begin
      hc_nxt = hc;
      vc_nxt = vc;
      if (run) begin
         if (hc == H_LAST) begin
            hc_nxt = '0;
            vc_nxt = (vc == V_LAST) ? '0 : vc + coord_t'(1);
         end else begin
            hc_nxt = hc + coord_t'(1);
         end
      end
   end

   assign blank_nxt = (hc_nxt < H_VIS_C) && (vc_nxt < V_VIS_C);
   assign fs_nxt    = (hc_nxt == '0) && (vc_nxt == '0);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         run         <= 1'b0;
         hc          <= '0;
         vc          <= '0;
         blank       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         run         <= 1'b1;
         hc          <= hc_nxt;
         vc          <= vc_nxt;
         blank       <= blank_nxt;
         frame_start <= fs_nxt;
      end
   end

   assign DrawX  = hc;
   assign DrawY  = vc;
   assign hs_raw = !((hc >= HS_START) && (hc < HS_END));
   assign vs_raw = !((vc >= VS_START) && (vc < VS_END));

   vga_delay_line #(
      .WIDTH   (2),
      .DEPTH   (SYNC_DLY),
      .RST_VAL (2'b11)
   ) u_sync_dly (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .d       ({hs_raw, vs_raw}),
      .q       ({hs_n, vs_n})
   );

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   // The start-up frame_start (run low) is not a completed frame.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q <= '0;
      end else if (run && fs_nxt) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_count = frame_cnt_q;
`else
   assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-mode instance for line-level timing and a reduced-mode
// instance (30x17 totals, no sync delay) for whole-frame behaviour.
module tb_vga_timing_gen;

   localparam int BH_TOT = 800, BV_TOT = 525;
   localparam int SH_TOT = 30,  SV_TOT = 17;
`ifdef VGA_TIMING_FRAME_CNT_EN
   localparam bit FC_EN = 1'b1;
`else
   localparam bit FC_EN = 1'b0;
`endif

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   always #20 vga_clk = ~vga_clk;

   logic [9:0]  b_x, b_y, s_x, s_y;
   logic        b_blank, b_hs, b_vs, b_fs, s_blank, s_hs, s_vs, s_fs;
   logic [15:0] b_fc, s_fc;

   vga_timing_gen u_dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(b_x), .DrawY(b_y), .blank(b_blank),
      .hs_n(b_hs), .vs_n(b_vs), .frame_start(b_fs), .frame_count(b_fc)
   );

   vga_timing_gen #(
      .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
      .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DLY(0)
   ) u_dut_small (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
      .hs_n(s_hs), .vs_n(s_vs), .frame_start(s_fs), .frame_count(s_fc)
   );

   int checks   = 0;
   int failures = 0;

   // Bench model of where each instance should be after the most recent edge.
   bit m_run = 1'b0;
   int bx = 0, by = 0, sx = 0, sy = 0;
   int b_fc_exp = 0, s_fc_exp = 0;

   task automatic model_reset();
      m_run = 1'b0; bx = 0; by = 0; sx = 0; sy = 0; b_fc_exp = 0; s_fc_exp = 0;
   endtask

   // Advance one clock; returns at the falling edge, where outputs are sampled.
   task automatic tick();
      logic rst_at_edge;
      @(posedge vga_clk);
      rst_at_edge = reset_n;
      @(negedge vga_clk);
      if (!rst_at_edge) begin
         model_reset();
      end else if (!m_run) begin
         m_run = 1'b1;
      end else begin
         if (bx == BH_TOT-1) begin
            bx = 0;
            by = (by == BV_TOT-1) ? 0 : by + 1;
            if (by == 0) b_fc_exp = (b_fc_exp + 1) % 65536;
         end else bx++;
         if (sx == SH_TOT-1) begin
            sx = 0;
            sy = (sy == SV_TOT-1) ? 0 : sy + 1;
            if (sy == 0) s_fc_exp = (s_fc_exp + 1) % 65536;
         end else sx++;
      end
   endtask

   task automatic run_to(input int x, input int y);
      int n = 0;
      while (!(bx == x && by == y) && n < 20000) begin
         tick();
         n++;
      end
      checks++;
      if (b_x !== 10'(x) || b_y !== 10'(y)) begin
         failures++;
         $display("FAIL run_to: got (%0d,%0d) expected (%0d,%0d)", b_x, b_y, x, y);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (10) begin
         tick();
         checks++;
         if ({b_x, b_y, b_blank, b_hs, b_vs, b_fs, b_fc, s_x, s_y, s_blank, s_hs, s_vs, s_fs, s_fc}
             !== {10'd0, 10'd0, 4'b0110, 16'd0, 10'd0, 10'd0, 4'b0110, 16'd0}) begin
            failures++;
            $display("FAIL reset_hold: big x=%0d y=%0d bl=%b hs=%b vs=%b fs=%b fc=%0d expected 0 0 0 1 1 0 0",
                     b_x, b_y, b_blank, b_hs, b_vs, b_fs, b_fc);
         end
      end
      #5 reset_n = 1'b1;
      tick();
      checks++;
      if ({b_x, b_y, b_fs, b_blank, b_fc, s_fs, s_blank, s_fc} !== {20'd0, 2'b11, 16'd0, 2'b11, 16'd0}) begin
         failures++;
         $display("FAIL first_cycle: x=%0d y=%0d fs=%b blank=%b fc=%0d small fs=%b blank=%b expected 0 0 1 1 0 1 1",
                  b_x, b_y, b_fs, b_blank, b_fc, s_fs, s_blank);
      end
      tick();
      checks++;
      if ({b_x, b_y, b_fs, b_blank} !== {10'd1, 10'd0, 2'b01}) begin
         failures++;
         $display("FAIL second_cycle: x=%0d y=%0d fs=%b blank=%b expected 1 0 0 1", b_x, b_y, b_fs, b_blank);
      end
   endtask

   // Two full small frames checked cycle by cycle, plus big-instance frame_start silence.
   task automatic test_small_frames();
      int pulses = 0, vs_low = 0;
      logic [38:0] got, exp;
      for (int c = 0; c < 2*SH_TOT*SV_TOT; c++) begin
         tick();
         exp = {10'(sx), 10'(sy), m_run && sx < 16 && sy < 10, !(sx >= 20 && sx < 26),
                !(sy >= 12 && sy < 14), m_run && sx == 0 && sy == 0, FC_EN ? 16'(s_fc_exp) : 16'd0};
         got = {s_x, s_y, s_blank, s_hs, s_vs, s_fs, s_fc};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL small_cycle: got %h expected %h at (%0d,%0d)", got, exp, sx, sy);
         end
         checks++;
         if ({b_x, b_y, b_fs} !== {10'(bx), 10'(by), bx == 0 && by == 0}) begin
            failures++;
            $display("FAIL big_track: got x=%0d y=%0d fs=%b expected x=%0d y=%0d", b_x, b_y, b_fs, bx, by);
         end
         if (s_vs === 1'b0) vs_low++;
         if (s_fs === 1'b1) begin
            pulses++;
            checks++;
            if (s_fc !== (FC_EN ? 16'(pulses) : 16'd0)) begin
               failures++;
               $display("FAIL frame_count: got %0d expected %0d", s_fc, FC_EN ? pulses : 0);
            end
         end
      end
      checks++;
      if (pulses != 2) begin
         failures++;
         $display("FAIL frame_pulses: got %0d expected 2", pulses);
      end
      checks++;
      if (vs_low != 2*2*SH_TOT) begin
         failures++;
         $display("FAIL vs_low_clocks: got %0d expected %0d", vs_low, 2*2*SH_TOT);
      end
   endtask

   task automatic test_line_wrap();
      run_to(639, 10);
      checks++;
      if (b_blank !== 1'b1) begin
         failures++;
         $display("FAIL blank_639: got %b expected 1", b_blank);
      end
      tick();
      checks++;
      if ({b_x, b_blank} !== {10'd640, 1'b0}) begin
         failures++;
         $display("FAIL blank_640: got x=%0d blank=%b expected 640 0", b_x, b_blank);
      end
      run_to(799, 10);
      tick();
      checks++;
      if ({b_x, b_y, b_blank, b_fs} !== {10'd0, 10'd11, 2'b10}) begin
         failures++;
         $display("FAIL line_wrap: got x=%0d y=%0d blank=%b fs=%b expected 0 11 1 0", b_x, b_y, b_blank, b_fs);
      end
   endtask

   task automatic test_hsync();
      int  n = 0;
      bit  vs_ok = 1'b1;
      run_to(657, 11);
      checks++;
      if (b_hs !== 1'b1) begin
         failures++;
         $display("FAIL hs_pre: got %b expected 1 at DrawX=657", b_hs);
      end
      tick();
      checks++;
      if (b_hs !== 1'b0) begin
         failures++;
         $display("FAIL hs_fall: got %b expected 0 at DrawX=658", b_hs);
      end
      while (b_hs === 1'b0 && n < 200) begin
         if (b_vs !== 1'b1) vs_ok = 1'b0;
         n++;
         tick();
      end
      checks++;
      if (n != 96 || b_x !== 10'd754) begin
         failures++;
         $display("FAIL hs_width: got %0d clocks ending at x=%0d expected 96 ending at 754", n, b_x);
      end
      checks++;
      if (!vs_ok) begin
         failures++;
         $display("FAIL vs_idle: got vs_n low during line 11 expected high");
      end
   endtask

   task automatic test_midframe_reset();
      run_to(300, 12);
      #5 reset_n = 1'b0;
      #1;
      checks++;
      if ({b_x, b_y, b_blank, b_hs, b_vs, b_fs, b_fc, s_x, s_y, s_blank, s_fs}
          !== {20'd0, 4'b0110, 16'd0, 20'd0, 2'b00}) begin
         failures++;
         $display("FAIL async_reset: x=%0d y=%0d bl=%b hs=%b vs=%b fs=%b fc=%0d expected 0 0 0 1 1 0 0",
                  b_x, b_y, b_blank, b_hs, b_vs, b_fs, b_fc);
      end
      model_reset();
      repeat (3) tick();
      #5 reset_n = 1'b1;
      tick();
      checks++;
      if ({b_x, b_y, b_fs, b_blank, b_fc} !== {20'd0, 2'b11, 16'd0}) begin
         failures++;
         $display("FAIL restart: got x=%0d y=%0d fs=%b blank=%b fc=%0d expected 0 0 1 1 0",
                  b_x, b_y, b_fs, b_blank, b_fc);
      end
      run_to(0, 1);
      checks++;
      if (b_fs !== 1'b0) begin
         failures++;
         $display("FAIL restart_line1: got fs=%b expected 0", b_fs);
      end
   endtask

   initial begin
      #(40 * 60000);
      $display("FAIL watchdog: simulation exceeded 60000 clocks");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_small_frames();
      test_line_wrap();
      test_hsync();
      test_midframe_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
